// File: rtl/pdu_decode_ctrl_pkg.sv
// Shared sizes, opcode sentinel, FSM encoding and bundle/list types for the PDU decode controller.
package pdu_decode_ctrl_pkg;
    localparam int NUM_LQ     = 8;
    localparam int NUM_PCH    = 16;
    localparam int LQADDR_BW  = 3;
    localparam int PCHADDR_BW = 4;
    localparam int OPCODE_BW  = 4;

    localparam logic [OPCODE_BW-1:0] INVALID_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef logic [NUM_LQ-1:0][1:0]                  lpp_t;
    typedef logic [NUM_LQ-1:0][OPCODE_BW-1:0]        op_t;
    typedef logic [NUM_LQ-1:0][LQADDR_BW-1:0]        mreg_t;
    // map[lq][1] = pchidx1, map[lq][0] = pchidx0
    typedef logic [NUM_LQ-1:0][1:0][PCHADDR_BW-1:0]  map_t;
    typedef logic [NUM_PCH-1:0][1:0]                 pchpp_t;
    typedef logic [NUM_PCH-1:0][OPCODE_BW-1:0]       pchop_t;
    typedef logic [NUM_PCH-1:0][LQADDR_BW-1:0]       pchmreg_t;

    typedef struct packed {
        lpp_t  lpp;
        op_t   op;
        mreg_t mreg;
        map_t  map;
    } bundle_t;

    localparam pchop_t PCHOP_IDLE = {NUM_PCH{INVALID_OPCODE}};
endpackage

// File: rtl/pdu_decode_ctrl_if.sv
// Bundle-in / merged-lists-out handshake bus of the PDU decode controller.
interface pdu_decode_ctrl_if;
    import pdu_decode_ctrl_pkg::*;

    logic     in_valid;
    logic     in_ready;
    lpp_t     lpplist;
    op_t      oplist;
    mreg_t    mreglist;
    map_t     lq2pch_map;
    logic     out_valid;
    logic     out_ready;
    logic [NUM_PCH-1:0] pch_list;
    pchpp_t   pchpp_list;
    pchop_t   pchop_list;
    pchmreg_t pchmreg_list;
    logic     conflict;

    modport master (
        output in_valid, lpplist, oplist, mreglist, lq2pch_map, out_ready,
        input  in_ready, out_valid, pch_list, pchpp_list, pchop_list, pchmreg_list, conflict
    );

    modport slave (
        input  in_valid, lpplist, oplist, mreglist, lq2pch_map, out_ready,
        output in_ready, out_valid, pch_list, pchpp_list, pchop_list, pchmreg_list, conflict
    );
endinterface

// File: rtl/pdu_decode_ctrl_decoder.sv
// Combinational per-LQ decoder: selects one LQ's fields and expands its patch pair to a one-hot-ish mask.
module pdu_decode_ctrl_decoder
    import pdu_decode_ctrl_pkg::*;
(
    input  bundle_t                bundle,
    input  logic [LQADDR_BW-1:0]   lqidx,
    output logic [NUM_PCH-1:0]     pch_list_curr,
    output logic [1:0]             pp,
    output logic [OPCODE_BW-1:0]   op,
    output logic [LQADDR_BW-1:0]   mreg
);
    logic [PCHADDR_BW-1:0] rd_pchidx0, rd_pchidx1;

    assign rd_pchidx0 = bundle.map[lqidx][0];
    assign rd_pchidx1 = bundle.map[lqidx][1];
    assign pp         = bundle.lpp[lqidx];
    assign op         = bundle.op[lqidx];
    assign mreg       = bundle.mreg[lqidx];

    // An index beyond NUM_PCH simply never matches a patch lane.
    for (genvar p = 0; p < NUM_PCH; p++) begin : g_pch
        assign pch_list_curr[p] = (int'(rd_pchidx0) == p) || (int'(rd_pchidx1) == p);
    end
endmodule

// File: rtl/pdu_decode_ctrl.sv
// Scans one latched bundle LQ by LQ and merges per-LQ decode results into patch-wide lists.
module pdu_decode_ctrl
    import pdu_decode_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    pdu_decode_ctrl_if.slave  bus
);
    state_t                 state;
    logic [LQADDR_BW-1:0]   lq_cnt;
    bundle_t                snap;

    logic                   in_ready_q, out_valid_q, conflict_q;
    logic [NUM_PCH-1:0]     pch_list_q;
    pchpp_t                 pchpp_q;
    pchop_t                 pchop_q;
    pchmreg_t               pchmreg_q;

    logic [NUM_PCH-1:0]     cur_pch;
    logic [1:0]             cur_pp;
    logic [OPCODE_BW-1:0]   cur_op;
    logic [LQADDR_BW-1:0]   cur_mreg;

    pdu_decode_ctrl_decoder u_dec (
        .bundle        (snap),
        .lqidx         (lq_cnt),
        .pch_list_curr (cur_pch),
        .pp            (cur_pp),
        .op            (cur_op),
        .mreg          (cur_mreg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lq_cnt      <= '0;
            snap        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            conflict_q  <= 1'b0;
            pch_list_q  <= '0;
            pchpp_q     <= '0;
            pchop_q     <= PCHOP_IDLE;
            pchmreg_q   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    snap.lpp    <= bus.lpplist;
                    snap.op     <= bus.oplist;
                    snap.mreg   <= bus.mreglist;
                    snap.map    <= bus.lq2pch_map;
                    lq_cnt      <= '0;
                    conflict_q  <= 1'b0;
                    pch_list_q  <= '0;
                    pchpp_q     <= '0;
                    pchop_q     <= PCHOP_IDLE;
                    pchmreg_q   <= '0;
                    in_ready_q  <= 1'b0;
                    state       <= SCAN;
                end
                SCAN: begin
                    // First LQ to claim a patch keeps it; any later claim only raises conflict.
                    if (cur_op != INVALID_OPCODE) begin
                        for (int p = 0; p < NUM_PCH; p++) begin
                            if (cur_pch[p]) begin
                                if (!pch_list_q[p]) begin
                                    pch_list_q[p] <= 1'b1;
                                    pchpp_q[p]    <= cur_pp;
                                    pchop_q[p]    <= cur_op;
                                    pchmreg_q[p]  <= cur_mreg;
                                end else begin
                                    conflict_q    <= 1'b1;
                                end
                            end
                        end
                    end
                    lq_cnt <= lq_cnt + LQADDR_BW'(1);
                    if (lq_cnt == LQADDR_BW'(NUM_LQ - 1)) begin
                        out_valid_q <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.conflict     = conflict_q;
    assign bus.pch_list     = pch_list_q;
    assign bus.pchpp_list   = pchpp_q;
    assign bus.pchop_list   = pchop_q;
    assign bus.pchmreg_list = pchmreg_q;
endmodule

// File: tb/tb_pdu_decode_ctrl.sv
// Self-checking bench for pdu_decode_ctrl: directed scenarios plus randomized bundles vs. an ownership model.
module tb_pdu_decode_ctrl;
    import pdu_decode_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    pdu_decode_ctrl_if bus();
    pdu_decode_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference: each patch is owned by the first valid LQ naming it; a second distinct LQ naming it is a conflict.
    task automatic model(input lpp_t l, input op_t o, input mreg_t m, input map_t mp,
                         output logic [NUM_PCH-1:0] ep, output pchpp_t epp, output pchop_t eop,
                         output pchmreg_t em, output logic ec);
        int owner [NUM_PCH];
        for (int p = 0; p < NUM_PCH; p++) owner[p] = -1;
        ec = 1'b0;
        for (int lq = 0; lq < NUM_LQ; lq++) begin
            if (o[lq] == INVALID_OPCODE) continue;
            for (int k = 0; k < 2; k++) begin
                int idx;
                idx = int'(mp[lq][k]);
                if (idx >= NUM_PCH) continue;
                if (owner[idx] < 0) owner[idx] = lq;
                else if (owner[idx] != lq) ec = 1'b1;
            end
        end
        ep = '0; epp = '0; eop = PCHOP_IDLE; em = '0;
        for (int p = 0; p < NUM_PCH; p++) begin
            if (owner[p] >= 0) begin
                ep[p]  = 1'b1;
                epp[p] = l[owner[p]];
                eop[p] = o[owner[p]];
                em[p]  = m[owner[p]];
            end
        end
    endtask

    task automatic rand_bundle(input int base, input int span, output lpp_t l, output op_t o,
                               output mreg_t m, output map_t mp);
        for (int lq = 0; lq < NUM_LQ; lq++) begin
            l[lq]     = 2'($urandom);
            o[lq]     = ($urandom_range(0, 3) == 0) ? INVALID_OPCODE : OPCODE_BW'($urandom_range(0, 14));
            m[lq]     = LQADDR_BW'($urandom);
            mp[lq][0] = PCHADDR_BW'(base + int'($urandom_range(0, span - 1)));
            mp[lq][1] = ($urandom_range(0, 1) == 1) ? mp[lq][0]
                                                     : PCHADDR_BW'(base + int'($urandom_range(0, span - 1)));
        end
    endtask

    // Accepts a bundle from IDLE, scrambles the inputs, and waits (bounded) for out_valid.
    task automatic run_bundle(input lpp_t l, input op_t o, input mreg_t m, input map_t mp, output int lat);
        @(negedge clk);
        bus.lpplist = l; bus.oplist = o; bus.mreglist = m; bus.lq2pch_map = mp;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.oplist     = op_t'($urandom);
        bus.lq2pch_map = map_t'({$urandom, $urandom});
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake;
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1; bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.pch_list !== '0) begin n_err++; $display("FAIL reset_pch_list got %h want 0", bus.pch_list); end
        n_cmp++; if (bus.pchop_list !== PCHOP_IDLE) begin n_err++; $display("FAIL reset_pchop got %h want %h", bus.pchop_list, PCHOP_IDLE); end
        n_cmp++; if (bus.conflict !== 1'b0 || bus.pchpp_list !== '0 || bus.pchmreg_list !== '0) begin
            n_err++; $display("FAIL reset_misc got conf=%b pp=%h mreg=%h want 0", bus.conflict, bus.pchpp_list, bus.pchmreg_list); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_single_lq;
        lpp_t l = '0; op_t o = {NUM_LQ{INVALID_OPCODE}}; mreg_t m = '0; map_t mp = '0; int lat;
        o[2] = 4'h3; l[2] = 2'b10; m[2] = 3'd3; mp[2][1] = 4'd5; mp[2][0] = 4'd4;
        run_bundle(l, o, m, mp, lat);
        n_cmp++; if (lat != NUM_LQ + 1) begin n_err++; $display("FAIL single_latency got %0d want %0d", lat, NUM_LQ + 1); end
        n_cmp++; if (bus.pch_list !== 16'h0030) begin n_err++; $display("FAIL single_pch_list got %h want 0030", bus.pch_list); end
        n_cmp++; if (bus.pchop_list[4] !== 4'h3 || bus.pchop_list[5] !== 4'h3) begin
            n_err++; $display("FAIL single_op got %h/%h want 3/3", bus.pchop_list[4], bus.pchop_list[5]); end
        n_cmp++; if (bus.pchpp_list[4] !== 2'b10 || bus.pchpp_list[5] !== 2'b10) begin
            n_err++; $display("FAIL single_pp got %b/%b want 10/10", bus.pchpp_list[4], bus.pchpp_list[5]); end
        n_cmp++; if (bus.pchmreg_list[4] !== 3'd3 || bus.pchmreg_list[5] !== 3'd3) begin
            n_err++; $display("FAIL single_mreg got %0d/%0d want 3/3", bus.pchmreg_list[4], bus.pchmreg_list[5]); end
        n_cmp++; if (bus.conflict !== 1'b0) begin n_err++; $display("FAIL single_conflict got %b want 0", bus.conflict); end
        handshake();
    endtask

    task automatic test_conflict;
        lpp_t l = '0; op_t o = {NUM_LQ{INVALID_OPCODE}}; mreg_t m = '0; map_t mp = '0; int lat;
        o[0] = 4'h1; mp[0][1] = 4'd1; mp[0][0] = 4'd1;
        o[3] = 4'h2; mp[3][1] = 4'd1; mp[3][0] = 4'd2;
        run_bundle(l, o, m, mp, lat);
        n_cmp++; if (bus.pch_list !== 16'h0006) begin n_err++; $display("FAIL conflict_pch_list got %h want 0006", bus.pch_list); end
        n_cmp++; if (bus.pchop_list[1] !== 4'h1) begin n_err++; $display("FAIL conflict_p1_op got %h want 1", bus.pchop_list[1]); end
        n_cmp++; if (bus.pchop_list[2] !== 4'h2) begin n_err++; $display("FAIL conflict_p2_op got %h want 2", bus.pchop_list[2]); end
        n_cmp++; if (bus.conflict !== 1'b1) begin n_err++; $display("FAIL conflict_flag got %b want 1", bus.conflict); end
        handshake();
    endtask

    task automatic test_random;
        lpp_t l; op_t o; mreg_t m; map_t mp; int lat;
        logic [NUM_PCH-1:0] ep; pchpp_t epp; pchop_t eop; pchmreg_t em; logic ec;
        for (int it = 0; it < 8; it++) begin
            rand_bundle(0, (it < 4) ? NUM_PCH : 6, l, o, m, mp);
            model(l, o, m, mp, ep, epp, eop, em, ec);
            run_bundle(l, o, m, mp, lat);
            n_cmp++; if (lat != NUM_LQ + 1) begin n_err++; $display("FAIL rand%0d_latency got %0d want %0d", it, lat, NUM_LQ + 1); end
            n_cmp++; if (bus.pch_list !== ep) begin n_err++; $display("FAIL rand%0d_pch_list got %h want %h", it, bus.pch_list, ep); end
            n_cmp++; if (bus.pchpp_list !== epp) begin n_err++; $display("FAIL rand%0d_pp got %h want %h", it, bus.pchpp_list, epp); end
            n_cmp++; if (bus.pchop_list !== eop) begin n_err++; $display("FAIL rand%0d_op got %h want %h", it, bus.pchop_list, eop); end
            n_cmp++; if (bus.pchmreg_list !== em) begin n_err++; $display("FAIL rand%0d_mreg got %h want %h", it, bus.pchmreg_list, em); end
            n_cmp++; if (bus.conflict !== ec) begin n_err++; $display("FAIL rand%0d_conflict got %b want %b", it, bus.conflict, ec); end
            handshake();
        end
    endtask

    task automatic test_backpressure;
        lpp_t l; op_t o; mreg_t m; map_t mp; int lat;
        logic [NUM_PCH-1:0] ep; pchpp_t epp; pchop_t eop; pchmreg_t em; logic ec;
        int bad = 0;
        rand_bundle(0, NUM_PCH, l, o, m, mp);
        model(l, o, m, mp, ep, epp, eop, em, ec);
        run_bundle(l, o, m, mp, lat);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.oplist = '0; bus.lq2pch_map = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.pch_list !== ep ||
                bus.pchop_list !== eop || bus.pchpp_list !== epp || bus.pchmreg_list !== em || bus.conflict !== ec)
                bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL backpressure_hold got %0d disturbed cycles want 0", bad); end
        @(negedge clk); bus.in_valid = 1'b0;
        handshake();
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL backpressure_release got rdy=%b vld=%b want 1/0", bus.in_ready, bus.out_valid); end
        repeat (NUM_LQ + 3) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL backpressure_ignored_in got vld=%b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back;
        lpp_t l; op_t o; mreg_t m; map_t mp; int lat;
        logic [NUM_PCH-1:0] ep; pchpp_t epp; pchop_t eop; pchmreg_t em; logic ec;
        rand_bundle(0, 8, l, o, m, mp);
        o[0] = 4'h5;
        run_bundle(l, o, m, mp, lat);
        handshake();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got %b want 1", bus.in_ready); end
        rand_bundle(8, 8, l, o, m, mp);
        o[1] = 4'h6;
        model(l, o, m, mp, ep, epp, eop, em, ec);
        run_bundle(l, o, m, mp, lat);
        n_cmp++; if (lat != NUM_LQ + 1) begin n_err++; $display("FAIL b2b_latency got %0d want %0d", lat, NUM_LQ + 1); end
        n_cmp++; if (bus.pch_list !== ep || bus.pchop_list !== eop) begin
            n_err++; $display("FAIL b2b_residue got pch=%h op=%h want pch=%h op=%h", bus.pch_list, bus.pchop_list, ep, eop); end
        n_cmp++; if (bus.pchpp_list !== epp || bus.pchmreg_list !== em || bus.conflict !== ec) begin
            n_err++; $display("FAIL b2b_fields got pp=%h mreg=%h c=%b want pp=%h mreg=%h c=%b",
                              bus.pchpp_list, bus.pchmreg_list, bus.conflict, epp, em, ec); end
        handshake();
    endtask

    task automatic test_reset_mid_scan;
        lpp_t l; op_t o; mreg_t m; map_t mp;
        int pulses = 0;
        rand_bundle(0, NUM_PCH, l, o, m, mp);
        o[0] = 4'h7;
        @(negedge clk);
        bus.lpplist = l; bus.oplist = o; bus.mreglist = m; bus.lq2pch_map = mp; bus.in_valid = 1'b1;
        @(posedge clk); #1; bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL midscan_reset got rdy=%b vld=%b want 1/0", bus.in_ready, bus.out_valid); end
        n_cmp++; if (bus.pch_list !== '0 || bus.pchop_list !== PCHOP_IDLE) begin
            n_err++; $display("FAIL midscan_clear got pch=%h op=%h want 0/%h", bus.pch_list, bus.pchop_list, PCHOP_IDLE); end
        @(negedge clk); rst = 1'b1; bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) pulses++;
        end
        bus.out_ready = 1'b0;
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL midscan_no_output got %0d pulses want 0", pulses); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.lpplist = '0; bus.oplist = '0; bus.mreglist = '0; bus.lq2pch_map = '0;
        test_reset();
        test_single_lq();
        test_conflict();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
